// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//
// Front-end controller for the serial sequence detector. Bytes arrive over a
// valid/ready handshake and are serialised MSB first, one bit per clock, into
// a bit-history register. The history is compared against a programmable
// pattern; each hit produces a one-cycle match pulse and bumps a saturating
// hit counter. Detection may be overlapping or non-overlapping. Pattern and
// mode can only be rewritten while the controller is idle.
//
// Ports
//   clk          in   1      clock, all flops on posedge
//   rst          in   1      asynchronous active-low reset
//   cfg_we       in   1      config write strobe (honoured only in IDLE)
//   cfg_pattern  in   PAT_W  new pattern, bit PAT_W-1 is the oldest bit
//   cfg_overlap  in   1      1 = overlapping, 0 = non-overlapping detection
//   in_valid     in   1      in_data valid
//   in_data      in   8      byte to serialise, bit 7 first
//   in_ready     out  1      byte accepted this cycle when in_valid is high
//   busy         out  1      controller is shifting a byte
//   match        out  1      one-cycle pulse per detected pattern
//   match_cnt    out  CNT_W  hits since reset/config, saturating
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
    parameter int unsigned      PAT_W       = 6,
    parameter int unsigned      CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(6'b101111)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    // fill must be able to hold the value PAT_W itself
    localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0]        r_buf;
    logic [2:0]        r_bit_idx;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;
    logic [CNT_W-1:0]  r_cnt;
    logic [PAT_W-1:0]  r_pattern;
    logic              r_overlap;

    logic              w_accept;
    logic              w_last_bit;
    logic              w_cfg_load;
    logic              w_bit;
    logic [PAT_W-1:0]  w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_hit;

    // ------------------------------------------------------------------
    // Datapath helper signals
    // ------------------------------------------------------------------
    assign w_accept    = in_valid && in_ready;
    assign w_last_bit  = (r_bit_idx == 3'd0);
    assign w_cfg_load  = cfg_we && (r_state == S_IDLE);
    assign w_bit       = r_buf[r_bit_idx];
    assign w_hist_next = {r_hist[PAT_W-2:0], w_bit};
    assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : (r_fill + FILL_W'(1));
    // A hit needs both the pattern in the window and a window full of bits
    // shifted since the last reset/config/non-overlap hit.
    assign w_hit       = (w_hist_next == r_pattern) && (w_fill_next == FILL_FULL);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // On the final bit a new byte may be taken so streams run
                // without a bubble.
                if (w_last_bit) begin
                    w_state_next = w_accept ? S_SHIFT : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = !cfg_we;
            S_SHIFT: begin
                in_ready = w_last_bit;
                busy     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte buffer, history, fill, match and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf     <= '0;
            r_bit_idx <= 3'd7;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_cnt     <= '0;
            r_pattern <= DEF_PATTERN;
            r_overlap <= 1'b1;
        end else begin
            r_match <= 1'b0;

            if (w_cfg_load) begin
                r_pattern <= cfg_pattern;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
                r_cnt     <= '0;
            end else if (r_state == S_SHIFT) begin
                r_hist    <= w_hist_next;
                r_match   <= w_hit;
                r_bit_idx <= r_bit_idx - 3'd1;
                // Non-overlapping mode restarts the fill count so the next
                // hit needs a full window of fresh bits; hist is kept.
                if (w_hit && !r_overlap) begin
                    r_fill <= '0;
                end else begin
                    r_fill <= w_fill_next;
                end
                if (w_hit && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // cfg load and accept are mutually exclusive: in_ready is low
            // whenever cfg_we is seen in IDLE.
            if (w_accept) begin
                r_buf     <= in_data;
                r_bit_idx <= 3'd7;
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//
// Bench for seq_detect_ctrl. Two instances share all inputs: the default
// configuration and one with a 4-bit counter to exercise saturation.
// A behavioural model tracks the serial bit stream and pattern hits; hits
// are queued with the edge they complete on and a monitor compares them
// against the DUT match pulses.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

    localparam int PAT_W = 6;
    localparam int MASK  = (1 << PAT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;

    logic             in_ready, busy, match;
    logic [7:0]       match_cnt;
    logic             in_ready4, busy4, match4;
    logic [3:0]       match_cnt4;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(6), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .match(match), .match_cnt(match_cnt)
    );

    seq_detect_ctrl #(.PAT_W(6), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .busy(busy4), .match(match4), .match_cnt(match_cnt4)
    );

    // ------------------------------------------------------------------
    // Counters and checker
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending bits as a queue, window as an integer,
    // 'fresh' = bits seen since the last clear.
    // ------------------------------------------------------------------
    typedef struct {
        longint edge_no;
        int     hits;
    } exp_t;

    bit     m_bitq[$];
    exp_t   sb[$];
    int     m_window, m_fresh, m_hits, m_pattern;
    bit     m_overlap;
    longint m_edge = 0;
    bit     m_acc = 0;
    int     m_pre;
    bit     m_rdy, m_b;

    function automatic void model_reset();
        m_bitq.delete();
        sb.delete();
        m_window  = 0;
        m_fresh   = 0;
        m_hits    = 0;
        m_pattern = 6'b101111;
        m_overlap = 1'b1;
        m_acc     = 1'b0;
    endfunction

    function automatic bit exp_ready();
        return (m_bitq.size() == 0 && !cfg_we) || (m_bitq.size() == 1);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        m_edge++;
        m_acc = 1'b0;
        if (rst) begin
            m_pre = m_bitq.size();
            m_rdy = exp_ready();
            if (m_pre > 0) begin
                m_b      = m_bitq.pop_front();
                m_window = ((m_window << 1) | int'(m_b)) & MASK;
                m_fresh++;
                if (m_fresh >= PAT_W && m_window == m_pattern) begin
                    m_hits++;
                    sb.push_back('{edge_no: m_edge, hits: m_hits});
                    if (!m_overlap) m_fresh = 0;
                end
            end
            if (cfg_we && m_pre == 0) begin
                m_pattern = int'(cfg_pattern);
                m_overlap = cfg_overlap;
                m_window  = 0;
                m_fresh   = 0;
                m_hits    = 0;
            end
            if (in_valid && m_rdy) begin
                for (int i = 7; i >= 0; i--) m_bitq.push_back(in_data[i]);
                m_acc = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------
    int   busy_run = 0;
    int   last_run = 0;
    bit   exp_m;
    exp_t e;

    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready());
        chk("in_ready4", in_ready4, exp_ready());
        chk("busy", busy, m_bitq.size() > 0);
        chk("busy4", busy4, m_bitq.size() > 0);
        chk("match_cnt", match_cnt, sat(m_hits, 255));
        chk("match_cnt4", match_cnt4, sat(m_hits, 15));

        exp_m = (sb.size() > 0) && (sb[0].edge_no == m_edge);
        chk("match4", match4, exp_m);
        if (match) begin
            if (!exp_m) begin
                chk("match_unexpected", match, 0);
            end else begin
                e = sb.pop_front();
                chk("match_cnt_at_hit", match_cnt, sat(e.hits, 255));
            end
        end else if (exp_m) begin
            chk("match_missed", match, 1);
            void'(sb.pop_front());
        end

        if (busy) busy_run++;
        else if (busy_run > 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep_valid);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40 && !got; t++) begin
            tick();
            got = m_acc;
        end
        if (!got) chk("accept_timeout", got, 1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        in_valid = 1'b0;
        t = 0;
        while (m_bitq.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        if (m_bitq.size() != 0) chk("idle_timeout", m_bitq.size(), 0);
        tick();
        tick();
    endtask

    task automatic do_cfg(input logic [PAT_W-1:0] pat, input bit ov);
        wait_idle();
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ov;
        tick();
        cfg_we = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (3) tick();
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // Default pattern 101111 appears at the end of 0x2F
        send_byte(8'h2F, 1'b0);
        wait_idle();
        chk("t1_cnt", match_cnt, 1);

        // All-ones pattern, overlapping: hits at bits 6..16
        do_cfg(6'b111111, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b0);
        wait_idle();
        chk("t2_cnt", match_cnt, 11);

        // Non-overlapping: hits at bits 6 and 12 only
        do_cfg(6'b111111, 1'b0);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b0);
        wait_idle();
        chk("t3_cnt", match_cnt, 2);

        // Saturation of both counter widths
        do_cfg(6'b111111, 1'b1);
        for (int i = 0; i < 40; i++) send_byte(8'hFF, 1'b1);
        wait_idle();
        chk("t4_cnt4_sat", match_cnt4, 15);
        chk("t4_cnt8_sat", match_cnt, 255);

        // Three back-to-back bytes keep busy high for 24 cycles
        do_cfg(6'b101111, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        wait_idle();
        chk("t5_busy_run", last_run, 24);

        // Config during SHIFT is ignored, then reset mid-byte
        send_byte(8'h2F, 1'b1);
        tick();
        cfg_we      = 1'b1;
        cfg_pattern = 6'b000000;
        cfg_overlap = 1'b0;
        tick();
        cfg_we = 1'b0;
        send_byte(8'h2F, 1'b0);
        chk("t6_cnt_before_rst", match_cnt, 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", match_cnt, 0);
        tick();
        rst = 1'b1;
        tick();
        send_byte(8'h2F, 1'b0);
        wait_idle();
        chk("t6_default_pattern", match_cnt, 1);

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 65) begin
                send_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                          1'($urandom_range(0, 1)));
            end else if (sel < 80) begin
                cfg_we      = 1'b1;
                cfg_pattern = ($urandom_range(0, 2) == 0) ? 6'b111111 : 6'($urandom);
                cfg_overlap = 1'($urandom_range(0, 1));
                tick();
                cfg_we = 1'b0;
            end else if (sel < 84) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 10)) tick();
            end
        end

        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
